// File: rtl/fft_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT with one shared butterfly and a dual-port RAM.
// Drives the bit-reversed load, the per-stage butterfly schedule with drain gaps, and the result unload.
module fft_seq_ctrl #(
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr,
  output logic             bf_en,
  output logic [LOG2N-1:0] bf_addr_a,
  output logic [LOG2N-1:0] bf_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [3:0]       stage,
  input  logic             out_ready,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_UNLOAD,
    S_DONE
  } state_e;

  localparam logic [LOG2N-1:0] ONE       = LOG2N'(1);
  localparam logic [LOG2N-1:0] CNT_LAST  = '1;
  localparam logic [LOG2N-2:0] K_LAST    = '1;
  localparam logic [3:0]       STG_LAST  = 4'(LOG2N - 1);
  localparam logic [3:0]       DRN_LAST  = 4'(BF_LAT - 1);

  state_e             r_state;
  state_e             w_next;
  logic [LOG2N-1:0]   r_cnt;
  logic [LOG2N-2:0]   r_k;
  logic [3:0]         r_stage;
  logic [3:0]         r_drn;

  logic [LOG2N-1:0]   w_rev;
  logic [LOG2N-1:0]   w_k;
  logic [LOG2N-1:0]   w_h;
  logic [LOG2N-1:0]   w_lo;
  logic [LOG2N-1:0]   w_hi;
  logic [LOG2N-1:0]   w_a;
  logic [LOG2N-1:0]   w_tw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (start) w_next = S_LOAD;
        S_LOAD:    if (in_valid && r_cnt == CNT_LAST) w_next = S_COMPUTE;
        S_COMPUTE: if (r_k == K_LAST) w_next = S_DRAIN;
        S_DRAIN:   if (r_drn == DRN_LAST) w_next = (r_stage != STG_LAST) ? S_COMPUTE : S_UNLOAD;
        S_UNLOAD:  if (out_ready && r_cnt == CNT_LAST) w_next = S_DONE;
        S_DONE:    w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Counters wrap naturally at their last value, so each phase leaves them at 0 for the next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_k     <= '0;
      r_stage <= '0;
      r_drn   <= '0;
    end else if (stop) begin
      r_cnt   <= '0;
      r_k     <= '0;
      r_stage <= '0;
      r_drn   <= '0;
    end else begin
      case (r_state)
        S_LOAD: if (in_valid) r_cnt <= r_cnt + ONE;
        S_COMPUTE: begin
          r_k   <= r_k + 1'b1;
          r_drn <= '0;
        end
        S_DRAIN: begin
          if (r_drn == DRN_LAST) begin
            r_drn <= '0;
            if (r_stage != STG_LAST) begin
              r_stage <= r_stage + 4'd1;
            end else begin
              r_stage <= '0;
              r_cnt   <= '0;
            end
          end else begin
            r_drn <= r_drn + 4'd1;
          end
        end
        S_UNLOAD: if (out_ready) r_cnt <= r_cnt + ONE;
        default: begin
          r_cnt   <= '0;
          r_k     <= '0;
          r_stage <= '0;
          r_drn   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_rev = '0;
    for (int unsigned i = 0; i < LOG2N; i++) w_rev[i] = r_cnt[LOG2N-1-i];
  end

  always_comb begin
    w_k  = {1'b0, r_k};
    w_h  = ONE << r_stage;
    w_lo = w_k & (w_h - ONE);
    w_hi = (w_k >> r_stage) << (r_stage + 4'd1);
    w_a  = w_hi + w_lo;
    w_tw = w_lo << (STG_LAST - r_stage);
  end

  always_comb begin
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    bf_en     = 1'b0;
    bf_addr_a = '0;
    bf_addr_b = '0;
    tw_idx    = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_last  = 1'b0;
    stage     = r_stage;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
        wr_addr  = w_rev;
      end
      S_COMPUTE: begin
        bf_en     = 1'b1;
        bf_addr_a = w_a;
        bf_addr_b = w_a + w_h;
        tw_idx    = w_tw[LOG2N-2:0];
      end
      S_UNLOAD: begin
        rd_en    = out_ready;
        rd_addr  = r_cnt;
        out_last = out_ready && (r_cnt == CNT_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl at N=8, BF_LAT=2: stimulus pushes expected
// write/butterfly/read records, a negedge monitor pops and compares them.
module tb_fft_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, wr_en, bf_en, rd_en, out_last, busy, done;
  logic [2:0] wr_addr, bf_addr_a, bf_addr_b, rd_addr;
  logic [1:0] tw_idx;
  logic [3:0] stage;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  logic prev_last = 1'b0;

  int          wr_q[$];
  logic [11:0] bf_q[$];
  logic [3:0]  rd_q[$];

  int wr_exp[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int bfa_exp[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int bfb_exp[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tw_exp[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_seq_ctrl #(.LOG2N(3), .BF_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .bf_en(bf_en), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b), .tw_idx(tw_idx),
    .stage(stage), .out_ready(out_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    logic [3:0]  r;
    if (!rst) begin
      prev_last = 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_addr", int'(wr_addr), wr_q.pop_front());
      end
      if (bf_en) begin
        if (bf_q.size() == 0) chk("bf_unexpected", 1, 0);
        else begin
          e = bf_q.pop_front();
          chk("bf_sched", int'({stage, bf_addr_a, bf_addr_b, tw_idx}), int'(e));
        end
      end
      if (rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          r = rd_q.pop_front();
          chk("rd_addr_last", int'({rd_addr, out_last}), int'(r));
        end
      end
      if (done || prev_last) chk("done_after_last", int'(done), int'(prev_last));
      if (done) n_done++;
      prev_last = out_last;
    end
  end

  task automatic push_load_and_bf();
    for (int i = 0; i < 8; i++) wr_q.push_back(wr_exp[i]);
    for (int i = 0; i < 12; i++)
      bf_q.push_back({4'(i / 4), 3'(bfa_exp[i]), 3'(bfb_exp[i]), 2'(tw_exp[i])});
  endtask

  task automatic wait_load();
    int cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("load_entry", int'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input bit gap);
    int acc = 0;
    int cyc = 0;
    while (acc < 8 && cyc < 64) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_count", acc, 8);
  endtask

  task automatic run_xfer(input bit gap, input bit stall, input bit keep);
    int cyc;
    logic [31:0] pat;
    push_load_and_bf();
    for (int i = 0; i < 8; i++) rd_q.push_back({3'(i), i == 7});
    wait_load();
    if (!keep) start = 1'b0;
    do_load(gap);
    @(negedge clk);
    chk("in_ready_drop", int'(in_ready), 0);
    pat = '0;
    cyc = 0;
    while (!rd_en && cyc < 64) begin
      pat = {pat[30:0], bf_en};
      cyc++;
      @(negedge clk);
    end
    chk("compute_cycles", cyc, 18);
    chk("bf_gap_pattern", int'(pat[17:0]), 18'b111100111100111100);
    cyc = 0;
    while (!done && cyc < 64) begin
      @(posedge clk); #1;
      out_ready = (stall && cyc >= 2 && cyc < 5) ? 1'b0 : 1'b1;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("done_seen", int'(done), 1);
    @(negedge clk);
    chk("done_width", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    @(negedge clk);
    chk("relaunch", int'(in_ready), int'(keep));
  endtask

  initial begin
    int cyc;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", int'({in_ready, wr_en, bf_en, rd_en, out_last, done}), 0);
    chk("rst_addrs", int'({wr_addr, bf_addr_a, bf_addr_b, tw_idx, rd_addr, stage}), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Plain transform: load order, full butterfly schedule, unload.
    start = 1'b1;
    run_xfer(1'b0, 1'b0, 1'b0);

    // Asynchronous reset after three accepted samples.
    start = 1'b1;
    wait_load();
    start = 1'b0;
    for (int i = 0; i < 3; i++) wr_q.push_back(wr_exp[i]);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_ready", int'({in_ready, wr_en}), 0);
    chk("async_rst_busy", int'(busy), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);

    // Gapped input and stalled unload.
    start = 1'b1;
    run_xfer(1'b1, 1'b1, 1'b0);

    // Abort in stage 1 with start still asserted.
    push_load_and_bf();
    start = 1'b1;
    wait_load();
    do_load(1'b0);
    cyc = 0;
    @(negedge clk);
    while (!(bf_en && stage == 4'd1) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_stage1", int'(stage), 1);
    @(posedge clk); #1;
    stop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_outs", int'({bf_en, stage, done}), 0);
    bf_q.delete();
    @(posedge clk); #1;
    stop = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_stays_idle", int'(busy), 0);
    end

    // Back-to-back with start held, then release.
    start = 1'b1;
    run_xfer(1'b0, 1'b0, 1'b1);
    run_xfer(1'b0, 1'b1, 1'b0);

    chk("done_pulses", n_done, 4);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("bf_q_empty", bf_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
